// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage core: NOP opcode, stall-vector stage
// indices and the default-width EX/MEM bundle.
package pipeline_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'h00;

    // Bit positions inside the stall controller's vector.
    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_EXC_W  = 32;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            wd;
        logic                  wreg;
        logic [PKG_DATA_W-1:0] wdata;
        logic [PKG_DATA_W-1:0] hi;
        logic [PKG_DATA_W-1:0] lo;
        logic                  sg_hilo;
        logic [7:0]            code;
        logic [PKG_DATA_W-1:0] mem_addr;
        logic [PKG_DATA_W-1:0] reg2;
        logic [PKG_DATA_W-1:0] pc;
        logic [PKG_EXC_W-1:0]  exc;
        logic                  dslot;
    } ex_mem_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: advance/bubble/hold under the stall vector,
// synchronous flush, multi-cycle scratch feedback and a stall-cycle counter.
module ex_mem_pipe
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = STAGE_EX,
    parameter int EXC_W   = 32,
    parameter int PERF_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  sg_stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [4:0]          ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_sg_hilo,
    input  logic [7:0]          ex_code,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_reg2,
    input  logic [DATA_W-1:0]   ex_pc,
    input  logic [EXC_W-1:0]    ex_exc,
    input  logic                ex_dslot,
    input  logic [2*DATA_W-1:0] in_hilo,
    input  logic [CNT_W-1:0]    in_count,
    output logic                mem_valid,
    output logic [4:0]          mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_sg_hilo,
    output logic [7:0]          mem_code,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_reg2,
    output logic [DATA_W-1:0]   mem_pc,
    output logic [EXC_W-1:0]    mem_exc,
    output logic                mem_dslot,
    output logic [2*DATA_W-1:0] out_hilo,
    output logic [CNT_W-1:0]    out_count,
    output logic [PERF_W-1:0]   stall_cycles
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              sg_hilo;
        logic [7:0]        code;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] reg2;
        logic [DATA_W-1:0] pc;
        logic [EXC_W-1:0]  exc;
        logic              dslot;
    } bundle_t;

    function automatic bundle_t bubble_payload();
        bundle_t b;
        b      = '0;
        b.code = EXE_NOP_OP;
        return b;
    endfunction

    bundle_t               pay_q, pay_d;
    logic [2*DATA_W-1:0]   hilo_q, hilo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic stall_in, stall_out;
    logic unused_stall_bits;

    assign stall_in          = sg_stall[STAGE];
    assign stall_out         = sg_stall[STAGE+1];
    assign unused_stall_bits = ^sg_stall;

    always_comb begin
        pay_d  = pay_q;
        hilo_d = '0;
        cnt_d  = '0;
        if (flush) begin
            pay_d = bubble_payload();
        end else if (!stall_in) begin
            pay_d.valid    = ex_valid;
            pay_d.wd       = ex_wd;
            pay_d.wreg     = ex_wreg;
            pay_d.wdata    = ex_wdata;
            pay_d.hi       = ex_hi;
            pay_d.lo       = ex_lo;
            pay_d.sg_hilo  = ex_sg_hilo;
            pay_d.code     = ex_code;
            pay_d.mem_addr = ex_mem_addr;
            pay_d.reg2     = ex_reg2;
            pay_d.pc       = ex_pc;
            pay_d.exc      = ex_exc;
            pay_d.dslot    = ex_dslot;
            // An empty slot must never commit a write or raise an exception.
            if (!ex_valid) begin
                pay_d.wreg    = 1'b0;
                pay_d.sg_hilo = 1'b0;
                pay_d.exc     = '0;
            end
        end else begin
            // EX is stalled: keep its multi-cycle scratch alive.
            hilo_d = in_hilo;
            cnt_d  = in_count;
            if (!stall_out) begin
                pay_d = bubble_payload();
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pay_q  <= bubble_payload();
            hilo_q <= '0;
            cnt_q  <= '0;
        end else begin
            pay_q  <= pay_d;
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (stall_in),
        .count (stall_cycles)
    );

    assign mem_valid    = pay_q.valid;
    assign mem_wd       = pay_q.wd;
    assign mem_wreg     = pay_q.wreg;
    assign mem_wdata    = pay_q.wdata;
    assign mem_hi       = pay_q.hi;
    assign mem_lo       = pay_q.lo;
    assign mem_sg_hilo  = pay_q.sg_hilo;
    assign mem_code     = pay_q.code;
    assign mem_mem_addr = pay_q.mem_addr;
    assign mem_reg2     = pay_q.reg2;
    assign mem_pc       = pay_q.pc;
    assign mem_exc      = pay_q.exc;
    assign mem_dslot    = pay_q.dslot;
    assign out_hilo     = hilo_q;
    assign out_count    = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: reference model compared every cycle plus
// hand-computed literal checks at each scenario.
module tb_ex_mem_pipe;

    localparam logic [7:0] NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  sg_stall;
    logic        flush;
    logic        ex_valid, ex_wreg, ex_sg_hilo, ex_dslot;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2, ex_pc, ex_exc;
    logic [7:0]  ex_code;
    logic [63:0] in_hilo;
    logic [1:0]  in_count;

    logic        mem_valid, mem_wreg, mem_sg_hilo, mem_dslot;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2, mem_pc, mem_exc;
    logic [7:0]  mem_code;
    logic [63:0] out_hilo;
    logic [1:0]  out_count;
    logic [15:0] stall_cycles;

    logic        s_valid, s_wreg, s_sg_hilo, s_dslot;
    logic [4:0]  s_wd;
    logic [31:0] s_wdata, s_hi, s_lo, s_mem_addr, s_reg2, s_pc, s_exc;
    logic [7:0]  s_code;
    logic [63:0] s_hilo;
    logic [1:0]  s_count;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .sg_stall(sg_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_sg_hilo(ex_sg_hilo), .ex_code(ex_code),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_pc(ex_pc), .ex_exc(ex_exc),
        .ex_dslot(ex_dslot), .in_hilo(in_hilo), .in_count(in_count),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_sg_hilo(mem_sg_hilo), .mem_code(mem_code),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_pc(mem_pc), .mem_exc(mem_exc),
        .mem_dslot(mem_dslot), .out_hilo(out_hilo), .out_count(out_count),
        .stall_cycles(stall_cycles)
    );

    ex_mem_pipe #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst), .sg_stall(sg_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_sg_hilo(ex_sg_hilo), .ex_code(ex_code),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_pc(ex_pc), .ex_exc(ex_exc),
        .ex_dslot(ex_dslot), .in_hilo(in_hilo), .in_count(in_count),
        .mem_valid(s_valid), .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata),
        .mem_hi(s_hi), .mem_lo(s_lo), .mem_sg_hilo(s_sg_hilo), .mem_code(s_code),
        .mem_mem_addr(s_mem_addr), .mem_reg2(s_reg2), .mem_pc(s_pc), .mem_exc(s_exc),
        .mem_dslot(s_dslot), .out_hilo(s_hilo), .out_count(s_count),
        .stall_cycles(s_stall_cycles)
    );

    // ---------------- reference model ----------------
    // The MEM slot is a record; each edge the slot either takes the EX record,
    // becomes empty, or keeps what it has. Scratch survives only while EX stalls.
    typedef struct {
        bit       valid;
        bit [4:0] wd;
        bit       wreg;
        bit [31:0] wdata, hi, lo;
        bit       sg_hilo;
        bit [7:0] code;
        bit [31:0] addr, reg2, pc, exc;
        bit       dslot;
    } slot_t;

    slot_t     m_slot;
    bit [63:0] m_hilo;
    bit [1:0]  m_count;
    int        m_stalls16, m_stalls4;

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: 0};
        s.code = NOP;
        return s;
    endfunction

    function automatic slot_t ex_slot();
        slot_t s;
        s.valid = ex_valid;   s.wd = ex_wd;       s.wdata = ex_wdata;
        s.hi = ex_hi;         s.lo = ex_lo;       s.code = ex_code;
        s.addr = ex_mem_addr; s.reg2 = ex_reg2;   s.pc = ex_pc;
        s.dslot = ex_dslot;
        s.wreg    = ex_valid && ex_wreg;
        s.sg_hilo = ex_valid && ex_sg_hilo;
        s.exc     = ex_valid ? ex_exc : 32'd0;
        return s;
    endfunction

    initial begin
        m_slot = empty_slot();
        m_hilo = 0; m_count = 0; m_stalls16 = 0; m_stalls4 = 0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_slot = empty_slot();
            m_hilo = 0; m_count = 0; m_stalls16 = 0; m_stalls4 = 0;
        end else begin
            bit ex_stalled, mem_stalled;
            ex_stalled  = sg_stall[3];
            mem_stalled = sg_stall[4];
            if (flush || !ex_stalled) begin
                m_hilo  = 0;
                m_count = 0;
            end else begin
                m_hilo  = in_hilo;
                m_count = in_count;
            end
            if (flush)            m_slot = empty_slot();
            else if (!ex_stalled) m_slot = ex_slot();
            else if (!mem_stalled) m_slot = empty_slot();
            if (ex_stalled) begin
                if (m_stalls16 < 65535) m_stalls16++;
                if (m_stalls4 < 15)     m_stalls4++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("valid",    512'(mem_valid),    512'(m_slot.valid));
        check("wd",       512'(mem_wd),       512'(m_slot.wd));
        check("wreg",     512'(mem_wreg),     512'(m_slot.wreg));
        check("wdata",    512'(mem_wdata),    512'(m_slot.wdata));
        check("hi",       512'(mem_hi),       512'(m_slot.hi));
        check("lo",       512'(mem_lo),       512'(m_slot.lo));
        check("sg_hilo",  512'(mem_sg_hilo),  512'(m_slot.sg_hilo));
        check("code",     512'(mem_code),     512'(m_slot.code));
        check("mem_addr", 512'(mem_mem_addr), 512'(m_slot.addr));
        check("reg2",     512'(mem_reg2),     512'(m_slot.reg2));
        check("pc",       512'(mem_pc),       512'(m_slot.pc));
        check("exc",      512'(mem_exc),      512'(m_slot.exc));
        check("dslot",    512'(mem_dslot),    512'(m_slot.dslot));
        check("out_hilo", 512'(out_hilo),     512'(m_hilo));
        check("out_count",512'(out_count),    512'(m_count));
        check("stall_cycles", 512'(stall_cycles), 512'(m_stalls16));
        check("sat_bundle",
              512'({s_valid, s_wd, s_wreg, s_wdata, s_hi, s_lo, s_sg_hilo, s_code,
                    s_mem_addr, s_reg2, s_pc, s_exc, s_dslot, s_hilo, s_count, s_stall_cycles}),
              512'({m_slot.valid, m_slot.wd, m_slot.wreg, m_slot.wdata, m_slot.hi, m_slot.lo,
                    m_slot.sg_hilo, m_slot.code, m_slot.addr, m_slot.reg2, m_slot.pc,
                    m_slot.exc, m_slot.dslot, m_hilo, m_count, 4'(m_stalls4)}));
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] wd, input logic [31:0] wdata,
                            input logic [7:0] code, input logic [31:0] exc);
        ex_valid = v;        ex_wd = wd;            ex_wreg = 1'b1;
        ex_wdata = wdata;    ex_hi = wdata ^ 32'h1111_1111;
        ex_lo = ~wdata;      ex_sg_hilo = 1'b1;     ex_code = code;
        ex_mem_addr = wdata + 32'h100; ex_reg2 = wdata - 32'h1;
        ex_pc = {wdata[15:0], 16'h0040}; ex_exc = exc; ex_dslot = wdata[0];
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; sg_stall = 6'b000000;
        in_hilo = 64'h0; in_count = 2'd0;
        drive_ex(1'b0, 5'd0, 32'h0, 8'h00, 32'h0);
        #1 rst = 1'b0;
        tick(); tick();
        check("lit_reset_code", 512'(mem_code), 512'(NOP));
        check("lit_reset_cnt",  512'(stall_cycles), 512'(0));
        rst = 1'b1;

        // Advance
        drive_ex(1'b1, 5'd9, 32'hDEADBEEF, 8'h21, 32'h0);
        tick();
        check("lit_adv_wd",    512'(mem_wd),    512'(9));
        check("lit_adv_wdata", 512'(mem_wdata), 512'(32'hDEADBEEF));
        check("lit_adv_valid", 512'(mem_valid), 512'(1));
        check("lit_adv_hilo",  512'(out_hilo),  512'(0));

        // Bubble with scratch
        sg_stall = 6'b001000; in_hilo = 64'h1_0000_0002; in_count = 2'd1;
        tick();
        check("lit_bub_valid", 512'(mem_valid), 512'(0));
        check("lit_bub_wreg",  512'(mem_wreg),  512'(0));
        check("lit_bub_hilo",  512'(out_hilo),  512'(64'h1_0000_0002));
        check("lit_bub_count", 512'(out_count), 512'(1));

        // Hold for 3 cycles with changing EX inputs
        sg_stall = 6'b000000;
        drive_ex(1'b1, 5'd3, 32'h1234_5678, 8'h2C, 32'h0000_0008);
        tick();
        sg_stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 5'(i + 20), $urandom(), 8'(i + 1), 32'h0);
            in_count = 2'(i);
            tick();
        end
        check("lit_hold_wdata", 512'(mem_wdata),    512'(32'h1234_5678));
        check("lit_hold_wd",    512'(mem_wd),       512'(3));
        check("lit_hold_exc",   512'(mem_exc),      512'(32'h8));
        check("lit_hold_cnt",   512'(stall_cycles), 512'(4));

        // Flush beats stall; counter keeps counting
        flush = 1'b1; in_count = 2'd2;
        tick();
        flush = 1'b0;
        check("lit_fl_code",  512'(mem_code),     512'(NOP));
        check("lit_fl_valid", 512'(mem_valid),    512'(0));
        check("lit_fl_count", 512'(out_count),    512'(0));
        check("lit_fl_cnt",   512'(stall_cycles), 512'(5));

        // Invalid slot advancing: side effects masked, data still carried
        sg_stall = 6'b000000;
        drive_ex(1'b0, 5'd7, 32'hCAFE_0001, 8'h10, 32'h0000_0200);
        tick();
        check("lit_inv_wreg",  512'(mem_wreg),    512'(0));
        check("lit_inv_hilo",  512'(mem_sg_hilo), 512'(0));
        check("lit_inv_exc",   512'(mem_exc),     512'(0));
        check("lit_inv_wdata", 512'(mem_wdata),   512'(32'hCAFE_0001));

        // Saturation of the 4-bit counter
        sg_stall = 6'b001000; in_hilo = 64'hAAAA_5555_0F0F_F0F0; in_count = 2'd3;
        for (int i = 0; i < 20; i++) tick();
        check("lit_sat4",  512'(s_stall_cycles), 512'(15));
        check("lit_sat16", 512'(stall_cycles),   512'(25));
        tick();
        check("lit_sat4_hold", 512'(s_stall_cycles), 512'(15));

        // Asynchronous reset with a payload latched
        sg_stall = 6'b000000;
        drive_ex(1'b1, 5'd31, 32'h5A5A_A5A5, 8'h33, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("lit_arst_wdata", 512'(mem_wdata),    512'(0));
        check("lit_arst_code",  512'(mem_code),     512'(NOP));
        check("lit_arst_cnt",   512'(stall_cycles), 512'(0));

        // Release reset mid-stall: first edge is a HOLD of the reset payload
        sg_stall = 6'b011000; in_hilo = 64'h0000_00FF_0000_0001; in_count = 2'd2;
        tick();
        rst = 1'b1;
        tick();
        check("lit_rel_code",  512'(mem_code),     512'(NOP));
        check("lit_rel_hilo",  512'(out_hilo),     512'(64'h0000_00FF_0000_0001));
        check("lit_rel_count", 512'(out_count),    512'(2));
        check("lit_rel_cnt",   512'(stall_cycles), 512'(1));

        sg_stall = 6'b000000;
        drive_ex(1'b1, 5'd1, 32'h0000_0042, 8'h05, 32'h0);
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
